// File: rtl/instrumentation_trip_unit_pkg.sv
// rtl/instrumentation_trip_unit_pkg.sv - shared command/mode types, channel indices and defaults
package instrumentation_trip_unit_pkg;

  typedef enum logic [1:0] {
    OP_SET_SETPOINT = 2'd0,
    OP_SET_MODE     = 2'd1,
    OP_RESET_TRIP   = 2'd2,
    OP_RESERVED     = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    MODE_OPERATE = 2'd0,
    MODE_BYPASS  = 2'd1,
    MODE_FORCE   = 2'd2,
    MODE_INVALID = 2'd3
  } mode_e;

  localparam logic [1:0] CH_TEMP    = 2'd0;
  localparam logic [1:0] CH_PRES    = 2'd1;
  localparam logic [1:0] CH_SAT     = 2'd2;
  localparam logic [1:0] CH_INVALID = 2'd3;

  localparam logic signed [31:0] DEF_SP_TEMP = 32'sd600;
  localparam logic signed [31:0] DEF_SP_PRES = 32'sd2000;
  localparam logic signed [31:0] DEF_SP_SAT  = 32'sd20;

  localparam logic [7:0] DEF_TRIP_CODE = 8'h01;

endpackage

// File: rtl/instrumentation_trip_unit_trip_channel.sv
// rtl/instrumentation_trip_unit_trip_channel.sv - one channel: setpoint compare, mode and sticky trip latch
module trip_channel
  import instrumentation_trip_unit_pkg::*;
#(
  parameter logic signed [31:0] DEFAULT_SP = 32'sd0,
  parameter bit                 TRIP_ABOVE = 1'b1,
  parameter logic [7:0]         TRIP_CODE  = DEF_TRIP_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               compare_en,
  input  logic signed [31:0] sample,
  input  logic               set_sp,
  input  logic               set_mode,
  input  logic               reset_trip,
  input  logic signed [31:0] cmd_data,
  output logic [7:0]         trip_byte
);

  logic signed [31:0] sp_q;
  logic [1:0]         mode_q;
  logic               latch_q;
  logic               raw_q;
  logic               raw_now;
  logic               latch_next;

  // Raw compare (equality never trips) and the latch value the compare would leave behind
  always_comb begin
    raw_now    = TRIP_ABOVE ? (sample > sp_q) : (sample < sp_q);
    latch_next = latch_q;
    case (mode_q)
      MODE_OPERATE: latch_next = latch_q | raw_now;
      MODE_BYPASS:  latch_next = 1'b0;
      default:      latch_next = latch_q;
    endcase
  end

  // Configuration, latch and output byte; the byte only moves on a compare
  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q      <= DEFAULT_SP;
      mode_q    <= MODE_OPERATE;
      latch_q   <= 1'b0;
      raw_q     <= 1'b0;
      trip_byte <= 8'h00;
    end else begin
      if (set_sp)   sp_q   <= cmd_data;
      if (set_mode) mode_q <= cmd_data[1:0];
      // A reset request is ignored while the last reading is still beyond the setpoint
      if (reset_trip && !raw_q) latch_q <= 1'b0;
      if (compare_en) begin
        raw_q   <= raw_now;
        latch_q <= latch_next;
        case (mode_q)
          MODE_OPERATE: trip_byte <= latch_next ? TRIP_CODE : 8'h00;
          MODE_FORCE:   trip_byte <= TRIP_CODE;
          default:      trip_byte <= 8'h00;
        endcase
      end
    end
  end

endmodule

// File: rtl/instrumentation_trip_unit.sv
// rtl/instrumentation_trip_unit.sv - two-stage sensor trip unit with command port and three trip channels
module instrumentation_trip_unit
  import instrumentation_trip_unit_pkg::*;
#(
  parameter logic [7:0] TRIP_CODE = DEF_TRIP_CODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sensor_valid,
  input  logic signed [31:0] temp_in,
  input  logic signed [31:0] pres_in,
  input  logic signed [31:0] sat_in,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [1:0]         cmd_ch,
  input  logic [31:0]        cmd_data,
  output logic [23:0]        trips,
  output logic               trips_valid,
  output logic               cmd_err
);

  logic               s1_valid;
  logic signed [31:0] s1_temp;
  logic signed [31:0] s1_pres;
  logic signed [31:0] s1_sat;
  logic               compare_en;
  logic               cmd_fire;
  logic               cmd_bad;
  logic               cmd_ok;
  logic [2:0]         ch_hit;
  logic [2:0]         set_sp;
  logic [2:0]         set_mode;
  logic [2:0]         reset_trip;
  logic [7:0]         byte_temp;
  logic [7:0]         byte_pres;
  logic [7:0]         byte_sat;

  // Commands are held off while a sample waits for its compare, so the compare sees stable settings
  assign cmd_ready = ~s1_valid;
  // A new strobe on top of a held sample replaces it, so that cycle performs no compare
  assign compare_en = s1_valid & ~sensor_valid;

  // Command decode: invalid channel, reserved op or mode 3 are accepted but change nothing
  always_comb begin
    cmd_fire   = cmd_valid & cmd_ready;
    cmd_bad    = (cmd_ch == CH_INVALID) || (cmd_op == OP_RESERVED) ||
                 ((cmd_op == OP_SET_MODE) && (cmd_data[1:0] == MODE_INVALID));
    cmd_ok     = cmd_fire & ~cmd_bad;
    ch_hit     = {cmd_ch == CH_SAT, cmd_ch == CH_PRES, cmd_ch == CH_TEMP};
    set_sp     = (cmd_ok && cmd_op == OP_SET_SETPOINT) ? ch_hit : 3'b000;
    set_mode   = (cmd_ok && cmd_op == OP_SET_MODE)     ? ch_hit : 3'b000;
    reset_trip = (cmd_ok && cmd_op == OP_RESET_TRIP)   ? ch_hit : 3'b000;
  end

  // Stage 1 capture plus the output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_temp     <= '0;
      s1_pres     <= '0;
      s1_sat      <= '0;
      trips_valid <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      s1_valid    <= sensor_valid;
      if (sensor_valid) begin
        s1_temp <= temp_in;
        s1_pres <= pres_in;
        s1_sat  <= sat_in;
      end
      trips_valid <= compare_en;
      cmd_err     <= cmd_fire & cmd_bad;
    end
  end

  trip_channel #(.DEFAULT_SP(DEF_SP_TEMP), .TRIP_ABOVE(1'b1), .TRIP_CODE(TRIP_CODE)) u_temp (
    .clk        (clk),
    .rst        (rst),
    .compare_en (compare_en),
    .sample     (s1_temp),
    .set_sp     (set_sp[0]),
    .set_mode   (set_mode[0]),
    .reset_trip (reset_trip[0]),
    .cmd_data   (cmd_data),
    .trip_byte  (byte_temp)
  );

  trip_channel #(.DEFAULT_SP(DEF_SP_PRES), .TRIP_ABOVE(1'b1), .TRIP_CODE(TRIP_CODE)) u_pres (
    .clk        (clk),
    .rst        (rst),
    .compare_en (compare_en),
    .sample     (s1_pres),
    .set_sp     (set_sp[1]),
    .set_mode   (set_mode[1]),
    .reset_trip (reset_trip[1]),
    .cmd_data   (cmd_data),
    .trip_byte  (byte_pres)
  );

  trip_channel #(.DEFAULT_SP(DEF_SP_SAT), .TRIP_ABOVE(1'b0), .TRIP_CODE(TRIP_CODE)) u_sat (
    .clk        (clk),
    .rst        (rst),
    .compare_en (compare_en),
    .sample     (s1_sat),
    .set_sp     (set_sp[2]),
    .set_mode   (set_mode[2]),
    .reset_trip (reset_trip[2]),
    .cmd_data   (cmd_data),
    .trip_byte  (byte_sat)
  );

  assign trips = {byte_temp, byte_pres, byte_sat};

endmodule
